// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin resource arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: search starts at i_ptr+1 and wraps.
module rr_pick
    import rr_arb_pkg::*;
(
    input  req_vec_t             i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_idx,
    output req_vec_t             o_onehot
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        cand     = i_ptr;
        found    = 1'b0;
        o_idx    = i_ptr;
        o_onehot = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = i_ptr + IDX_W'(k);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                o_idx = cand;
            end
        end
        if (found) begin
            o_onehot[o_idx] = 1'b1;
        end
        o_valid = found;
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one multi-cycle resource among 4 requesters.
// Define RR_ARB_TIMEOUT_EN to force-release grants held MAX_HOLD cycles.
module rr_resource_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_W = 8
`ifdef RR_ARB_TIMEOUT_EN
    ,
    parameter logic [HOLD_W-1:0] MAX_HOLD = HOLD_W'(200)
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_done,
    input  logic                 i_en,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [IDX_W-1:0]     o_gnt_idx,
    output logic                 o_busy,
    output logic [HOLD_W-1:0]    o_hold_cnt,
    output logic                 o_timeout
);

    arb_state_t         r_state;
    req_vec_t           r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_busy;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_timeout;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    req_vec_t           w_pick_onehot;
    logic               w_owner_done;
    logic               w_owner_req;
    logic               w_timeout;
    logic               w_release;
    logic               w_grant;

    // gnt_idx equals the last-served pointer whenever arbitration runs
    // (idle, or the release cycle where ptr takes the outgoing owner).
    rr_pick u_pick (
        .i_req    (i_req),
        .i_ptr    (r_gnt_idx),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    assign w_owner_done = i_done[r_gnt_idx];
    assign w_owner_req  = i_req[r_gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = MAX_HOLD - HOLD_W'(1);
    assign w_timeout = (r_state == ARB_BUSY) && w_owner_req && !w_owner_done
                       && (r_hold_cnt == HOLD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = (r_state == ARB_BUSY) && (w_owner_done || !w_owner_req || w_timeout);
    assign w_grant   = i_en && w_pick_valid;

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= IDX_W'(NUM_REQ - 1);
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_state    <= ARB_BUSY;
                        r_gnt      <= w_pick_onehot;
                        r_gnt_idx  <= w_pick_idx;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_release) begin
                        if (w_grant) begin
                            r_gnt      <= w_pick_onehot;
                            r_gnt_idx  <= w_pick_idx;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state    <= ARB_IDLE;
                            r_gnt      <= '0;
                            r_busy     <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_gnt_idx  = r_gnt_idx;
    assign o_busy     = r_busy;
    assign o_hold_cnt = r_hold_cnt;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Scoreboard bench for rr_resource_arbiter: reference model predicts each cycle's outputs.
module tb_rr_resource_arbiter;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int MAXH  = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAXH  = 200;
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic [7:0] hold;
        logic       to;
    } exp_t;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] i_done;
    logic       i_en;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_idx;
    logic       o_busy;
    logic [7:0] o_hold_cnt;
    logic       o_timeout;

    exp_t q[$];
    int   total;
    int   bad;
    int   m_owner;
    int   m_last;
    int   m_held;

`ifdef RR_ARB_TIMEOUT_EN
    rr_resource_arbiter #(.HOLD_W(8), .MAX_HOLD(8'(MAXH))) dut (
`else
    rr_resource_arbiter #(.HOLD_W(8)) dut (
`endif
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_done     (i_done),
        .i_en       (i_en),
        .o_gnt      (o_gnt),
        .o_gnt_idx  (o_gnt_idx),
        .o_busy     (o_busy),
        .o_hold_cnt (o_hold_cnt),
        .o_timeout  (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
    endtask

    // Apply one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input logic [3:0] req, input logic [3:0] done, input logic en);
        bit   rel;
        bit   to;
        exp_t e;
        @(negedge i_clk);
        i_req  = req;
        i_done = done;
        i_en   = en;
        rel = 1'b0;
        to  = 1'b0;
        if (m_owner >= 0) begin
            if (done[m_owner] || !req[m_owner]) rel = 1'b1;
            else if (TO_EN && m_held == MAXH - 1) begin
                rel = 1'b1;
                to  = 1'b1;
            end
            if (rel) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_held < 255) begin
                m_held++;
            end
        end
        if (m_owner < 0 && en) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_held  = 0;
                end
            end
        end
        e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.idx  = (m_owner >= 0) ? 2'(m_owner) : 2'(m_last);
        e.busy = (m_owner >= 0);
        e.hold = (m_owner >= 0) ? 8'(m_held) : 8'd0;
        e.to   = to;
        q.push_back(e);
    endtask

    task automatic reset_mid();
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_gnt", 32'(o_gnt), 32'h0);
        chk("async_rst_busy", 32'(o_busy), 32'h0);
        chk("async_rst_idx", 32'(o_gnt_idx), 32'h3);
        chk("async_rst_hold", 32'(o_hold_cnt), 32'h0);
        model_reset();
        @(negedge i_clk);
        i_req   = '0;
        i_done  = '0;
        i_en    = 1'b0;
        i_rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued predictions.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {o_gnt, o_gnt_idx, o_busy, o_hold_cnt, o_timeout};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs: got gnt=%b idx=%0d busy=%b hold=%0d to=%b want gnt=%b idx=%0d busy=%b hold=%0d to=%b",
                             got.gnt, got.idx, got.busy, got.hold, got.to,
                             e.gnt, e.idx, e.busy, e.hold, e.to);
                end
                total++;
                if ($countones(o_gnt) > 1) begin
                    bad++;
                    $display("FAIL onehot: got gnt=%b want at most one bit set", o_gnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  rq;
        logic [3:0]  dn;
        total   = 0;
        bad     = 0;
        i_rst_n = 1'b0;
        i_req   = '0;
        i_done  = '0;
        i_en    = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_idx", 32'(o_gnt_idx), 32'h3);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_hold", 32'(o_hold_cnt), 32'h0);
        chk("rst_to", 32'(o_timeout), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Full rotation with all requesters active.
        step(4'hF, 4'h0, 1'b1);
        step(4'hF, 4'h0, 1'b1);
        step(4'hF, 4'b0001, 1'b1);
        step(4'hF, 4'b0010, 1'b1);
        step(4'hF, 4'b0100, 1'b1);
        step(4'hF, 4'b1000, 1'b1);
        step(4'hF, 4'b0001, 1'b1);
        step(4'h0, 4'h0, 1'b1);
        step(4'h0, 4'h0, 1'b1);

        // Single requester, release, then pointer-ordered pick.
        repeat (6) step(4'b0100, 4'h0, 1'b1);
        step(4'b0000, 4'b0100, 1'b1);
        step(4'b0101, 4'h0, 1'b1);
        step(4'b0101, 4'h0, 1'b1);
        step(4'b0000, 4'h0, 1'b1);

        // Non-owner done ignored, then abort by dropped request.
        step(4'b0010, 4'h0, 1'b1);
        repeat (2) step(4'b0010, 4'b1101, 1'b1);
        step(4'b0000, 4'h0, 1'b1);

        // Enable gating in idle and busy.
        repeat (3) step(4'hF, 4'h0, 1'b0);
        step(4'hF, 4'h0, 1'b1);
        repeat (2) step(4'hF, 4'h0, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        step(4'h0, 4'h0, 1'b0);

        // Long hold: saturation (or forced release with timeout enabled).
        repeat (270) step(4'b0001, 4'h0, 1'b1);
        step(4'b0000, 4'h0, 1'b1);

        // Sole owner re-granted after done while still requesting.
        step(4'b1000, 4'h0, 1'b1);
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b1000, 4'h0, 1'b1);
        step(4'b0000, 4'h0, 1'b1);

        repeat (2000) begin
            r  = $urandom;
            rq = 4'(r) | 4'(r >> 4);
            dn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step(rq, dn, ($urandom_range(0, 6) != 0));
        end

        repeat (3) step(4'hF, 4'h0, 1'b1);
        reset_mid();

        repeat (1500) begin
            r  = $urandom;
            rq = 4'(r) | 4'(r >> 4) | 4'(r >> 8);
            dn = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            step(rq, dn, ($urandom_range(0, 9) != 0));
        end

        step(4'h0, 4'h0, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        @(posedge i_clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
